water_dispenser_controller: RTL and testbench
=============================================

Name: water_dispenser_controller

Overview:
Second-generation dispenser front end. Takes a keypad-style time entry, a digit per `button_add` press. On `button_ok` it opens the valve for the entered number of seconds using a parametrised tick divider. On completion it emits a done pulse and returns to entry; `button_cancel` aborts either phase. It sits between the switch/button debouncers and the valve driver and display.

Parameters:
RADIX, 10, number of digit switches and numeric base of the entry (digit value = switch index)
DIGIT_COUNT, 4, maximum digits accepted per entry
TIME_WIDTH, 14, width of entered/remaining time; must hold RADIX**DIGIT_COUNT-1 (design-time check, no runtime overflow handling)
TICKS_PER_SECOND, 50000000, clock cycles per dispensed second (>=2)

Ports:
clock  input  1  system clock, all logic on rising edge
reset  input  1  asynchronous, active-high; clears all state
switches  input  RADIX  digit select levels, already synchronised
button_add  input  1  append-digit button level, debounced and synchronised
button_ok  input  1  start-dispense button level
button_cancel  input  1  clear/abort button level
entered_time  output  TIME_WIDTH  value being keyed in (seconds)
remaining_time  output  TIME_WIDTH  seconds left while dispensing, else 0
digit_count  output  $clog2(DIGIT_COUNT+1)  digits accepted so far
valve_open  output  1  registered valve enable
done_pulse  output  1  high for exactly one cycle when a dispense completes normally
state_code  output  2  0=ENTRY, 1=DISPENSING, 2=DONE

Behaviour:
- Reset (async):
  - state=ENTRY
  - entered_time=0, remaining_time=0, digit_count=0, valve_open=0, done_pulse=0
  - tick counter=0
  - previous-level registers of all three buttons=1, so a button held through reset generates no press.
- Press detection: press = level & ~previous level. One press per rising level; held buttons act once.
- Priority on the same cycle: cancel > ok > add.
- ENTRY, add press:
  - Accepted only if digit_count<DIGIT_COUNT and at least one switch is high.
  - d = lowest index with switches[d]=1.
  - Next edge: entered_time<=entered_time*RADIX+d and digit_count+1.
  - No switch high, or entry full: no change.
  - Digit 0 is accepted and counts as a digit.
- ENTRY, ok press:
  - entered_time=0: ignored.
  - Otherwise, next edge: state=DISPENSING, remaining_time<=entered_time, valve_open<=1, tick<=0.
  - entered_time and digit_count hold their values.
- ENTRY, cancel press: entered_time<=0, digit_count<=0.
- DISPENSING:
  - Tick counts 0..TICKS_PER_SECOND-1.
  - At tick=TICKS_PER_SECOND-1: tick<=0 and remaining_time<=remaining_time-1.
  - If remaining_time was 1: state<=DONE, valve_open<=0.
  - valve_open is therefore high for exactly N*TICKS_PER_SECOND cycles for entry N.
  - Add and ok presses are ignored.
  - Cancel press, next edge: valve_open<=0, remaining_time<=0, entered_time<=0, digit_count<=0, tick<=0, state=ENTRY, no done_pulse.
- DONE:
  - Lasts exactly one cycle with done_pulse=1 and remaining_time=0.
  - Next edge: state=ENTRY, entered_time<=0, digit_count<=0.
  - All presses during DONE are ignored.
- Reset mid-dispense closes the valve immediately (asynchronous) and returns to ENTRY with everything cleared.
- All outputs are registered. No combinational path from inputs to outputs.

Test Plan:
- Reset with button_add held high, release and press again -> exactly one digit accepted after reset.
- Switches 3'b... pattern {switch 2 and 7 high}, add; then switch 5, add -> entered_time 2 then 25, digit_count 2.
- Five adds with switch 9 (DIGIT_COUNT=4) -> entered_time 9999, digit_count 4, fifth press ignored; add with no switch -> no change.
- TICKS_PER_SECOND=4, entry 3, ok:
  - valve_open high exactly 12 cycles; remaining_time 3,2,1 each for 4 cycles.
  - done_pulse one cycle, coincident with state_code=2.
  - Then entered_time=0 in ENTRY.
- Dispense 5 s, cancel at second 2 -> valve closes next edge, state_code=0, done_pulse never asserts; ok with entered_time=0 afterwards is ignored.
- Cancel, ok and add pressed on the same cycle in ENTRY with entered_time=7 -> cleared to 0, no dispense; async reset asserted mid-cycle during DISPENSING -> valve_open drops before next clock edge.

Source files
------------

// File: rtl/water_dispenser_controller_if.sv
`default_nettype none
// ============================================================================
// Module   : water_dispenser_controller_if
// Purpose  : Button/switch inputs and valve/display outputs of the dispenser
// Revision : 1.0  initial release
// ============================================================================
interface water_dispenser_controller_if #(
   parameter int RADIX       = 10,
   parameter int DIGIT_COUNT = 4,
   parameter int TIME_WIDTH  = 14
);
   localparam int c_COUNT_WIDTH = $clog2(DIGIT_COUNT + 1);

   logic [RADIX-1:0]         switches;
   logic                     button_add;
   logic                     button_ok;
   logic                     button_cancel;
   logic [TIME_WIDTH-1:0]    entered_time;
   logic [TIME_WIDTH-1:0]    remaining_time;
   logic [c_COUNT_WIDTH-1:0] digit_count;
   logic                     valve_open;
   logic                     done_pulse;
   logic [1:0]               state_code;

   modport master (
      output switches, button_add, button_ok, button_cancel,
      input  entered_time, remaining_time, digit_count, valve_open, done_pulse, state_code
   );

   modport slave (
      input  switches, button_add, button_ok, button_cancel,
      output entered_time, remaining_time, digit_count, valve_open, done_pulse, state_code
   );
endinterface

`default_nettype wire

// File: rtl/water_dispenser_controller.sv
`default_nettype none
// ============================================================================
// Module   : water_dispenser_controller
// Purpose  : Keypad time entry, timed valve dispense and completion pulse
// Revision : 1.0  initial release
// ============================================================================
module water_dispenser_controller #(
   parameter int RADIX            = 10,
   parameter int DIGIT_COUNT      = 4,
   parameter int TIME_WIDTH       = 14,
   parameter int TICKS_PER_SECOND = 50000000
) (
   input wire logic                    clock,
   input wire logic                    reset,
   water_dispenser_controller_if.slave bus
);
   localparam int c_COUNT_WIDTH = $clog2(DIGIT_COUNT + 1);
   localparam int c_DIGIT_WIDTH = (RADIX > 1) ? $clog2(RADIX) : 1;
   localparam int c_TICK_WIDTH  = $clog2(TICKS_PER_SECOND);

   localparam logic [c_TICK_WIDTH-1:0]  c_TICK_LAST  = c_TICK_WIDTH'(TICKS_PER_SECOND - 1);
   localparam logic [c_COUNT_WIDTH-1:0] c_DIGITS_MAX = c_COUNT_WIDTH'(DIGIT_COUNT);
   localparam logic [TIME_WIDTH-1:0]    c_RADIX_T    = TIME_WIDTH'(RADIX);

   localparam logic [1:0] c_ENTRY      = 2'd0;
   localparam logic [1:0] c_DISPENSING = 2'd1;
   localparam logic [1:0] c_DONE       = 2'd2;

   generate
      if (RADIX ** DIGIT_COUNT - 1 >= 2 ** TIME_WIDTH) begin : g_time_width_check
         $error("TIME_WIDTH cannot hold RADIX**DIGIT_COUNT-1");
      end
      if (TICKS_PER_SECOND < 2) begin : g_tick_check
         $error("TICKS_PER_SECOND must be at least 2");
      end
   endgenerate

   logic [1:0]               r_state;
   logic [TIME_WIDTH-1:0]    r_entered;
   logic [TIME_WIDTH-1:0]    r_remaining;
   logic [c_COUNT_WIDTH-1:0] r_digits;
   logic [c_TICK_WIDTH-1:0]  r_tick;
   logic                     r_valve;
   logic                     r_done;
   logic                     r_prev_add;
   logic                     r_prev_ok;
   logic                     r_prev_cancel;

   logic [1:0]               w_state_nxt;
   logic [TIME_WIDTH-1:0]    w_entered_nxt;
   logic [TIME_WIDTH-1:0]    w_remaining_nxt;
   logic [c_COUNT_WIDTH-1:0] w_digits_nxt;
   logic [c_TICK_WIDTH-1:0]  w_tick_nxt;
   logic                     w_valve_nxt;
   logic                     w_done_nxt;

   logic                     w_add_rise;
   logic                     w_ok_rise;
   logic                     w_cancel_press;
   logic                     w_ok_press;
   logic                     w_add_press;
   logic                     w_any_switch;
   logic [c_DIGIT_WIDTH-1:0] w_digit;
   logic                     w_add_accept;
   logic                     w_ok_accept;
   logic                     w_tick_last;
   logic                     w_last_second;
   logic [TIME_WIDTH-1:0]    w_shifted;

   // A higher-priority press masks lower ones even when it is itself ignored.
   assign w_add_rise     = bus.button_add & ~r_prev_add;
   assign w_ok_rise      = bus.button_ok & ~r_prev_ok;
   assign w_cancel_press = bus.button_cancel & ~r_prev_cancel;
   assign w_ok_press     = w_ok_rise & ~w_cancel_press;
   assign w_add_press    = w_add_rise & ~w_ok_rise & ~w_cancel_press;

   always_comb begin
      w_digit = '0;
      for (int i = RADIX - 1; i >= 0; i--) begin
         if (bus.switches[i]) begin
            w_digit = c_DIGIT_WIDTH'(i);
         end
      end
   end

   assign w_any_switch  = |bus.switches;
   assign w_add_accept  = w_add_press && w_any_switch && (r_digits < c_DIGITS_MAX);
   assign w_ok_accept   = w_ok_press && (r_entered != '0);
   assign w_tick_last   = (r_tick == c_TICK_LAST);
   assign w_last_second = (r_remaining == TIME_WIDTH'(1));
   assign w_shifted     = r_entered * c_RADIX_T + TIME_WIDTH'(w_digit);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state       <= c_ENTRY;
         r_entered     <= '0;
         r_remaining   <= '0;
         r_digits      <= '0;
         r_tick        <= '0;
         r_valve       <= 1'b0;
         r_done        <= 1'b0;
         r_prev_add    <= 1'b1;
         r_prev_ok     <= 1'b1;
         r_prev_cancel <= 1'b1;
      end else begin
         r_state       <= w_state_nxt;
         r_entered     <= w_entered_nxt;
         r_remaining   <= w_remaining_nxt;
         r_digits      <= w_digits_nxt;
         r_tick        <= w_tick_nxt;
         r_valve       <= w_valve_nxt;
         r_done        <= w_done_nxt;
         r_prev_add    <= bus.button_add;
         r_prev_ok     <= bus.button_ok;
         r_prev_cancel <= bus.button_cancel;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         c_ENTRY: begin
            if (w_ok_accept) begin
               w_state_nxt = c_DISPENSING;
            end
         end
         c_DISPENSING: begin
            if (w_cancel_press) begin
               w_state_nxt = c_ENTRY;
            end else if (w_tick_last && w_last_second) begin
               w_state_nxt = c_DONE;
            end
         end
         c_DONE:  w_state_nxt = c_ENTRY;
         default: w_state_nxt = c_ENTRY;
      endcase
   end

   always_comb begin
      w_entered_nxt   = r_entered;
      w_remaining_nxt = r_remaining;
      w_digits_nxt    = r_digits;
      w_tick_nxt      = r_tick;
      case (r_state)
         c_ENTRY: begin
            if (w_cancel_press) begin
               w_entered_nxt = '0;
               w_digits_nxt  = '0;
            end else if (w_ok_accept) begin
               w_remaining_nxt = r_entered;
               w_tick_nxt      = '0;
            end else if (w_add_accept) begin
               w_entered_nxt = w_shifted;
               w_digits_nxt  = r_digits + c_COUNT_WIDTH'(1);
            end
         end
         c_DISPENSING: begin
            if (w_cancel_press) begin
               w_entered_nxt   = '0;
               w_digits_nxt    = '0;
               w_remaining_nxt = '0;
               w_tick_nxt      = '0;
            end else if (w_tick_last) begin
               w_tick_nxt      = '0;
               w_remaining_nxt = r_remaining - TIME_WIDTH'(1);
            end else begin
               w_tick_nxt = r_tick + c_TICK_WIDTH'(1);
            end
         end
         default: begin
            w_entered_nxt   = '0;
            w_digits_nxt    = '0;
            w_remaining_nxt = '0;
            w_tick_nxt      = '0;
         end
      endcase
   end

   assign w_valve_nxt = (w_state_nxt == c_DISPENSING);
   assign w_done_nxt  = (w_state_nxt == c_DONE);

   assign bus.entered_time   = r_entered;
   assign bus.remaining_time = r_remaining;
   assign bus.digit_count    = r_digits;
   assign bus.valve_open     = r_valve;
   assign bus.done_pulse     = r_done;
   assign bus.state_code     = r_state;

endmodule

`default_nettype wire

// File: tb/tb_water_dispenser_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_water_dispenser_controller
// Purpose  : Scoreboard bench with a keystroke/elapsed-time reference model
// Revision : 1.0  initial release
// ============================================================================
module tb_water_dispenser_controller;
   localparam int RADIX       = 10;
   localparam int DIGIT_COUNT = 4;
   localparam int TIME_WIDTH  = 14;
   localparam int TICKS       = 4;

   typedef struct {
      int entered;
      int remaining;
      int digits;
      int valve;
      int done;
      int state;
   } snap_t;

   logic  clock = 1'b0;
   logic  reset = 1'b0;
   int    n_cmp = 0;
   int    n_err = 0;
   snap_t exp_q[$];

   // Reference model: the entry is the list of keys typed, dispensing is
   // described by its length in seconds and the cycles elapsed since ok.
   int    m_keys[$];
   int    m_mode = 0;
   int    m_secs = 0;
   int    m_elapsed = 0;
   bit    m_prev_add = 1'b1, m_prev_ok = 1'b1, m_prev_cancel = 1'b1;

   water_dispenser_controller_if #(
      .RADIX(RADIX), .DIGIT_COUNT(DIGIT_COUNT), .TIME_WIDTH(TIME_WIDTH)
   ) bus ();

   water_dispenser_controller #(
      .RADIX(RADIX), .DIGIT_COUNT(DIGIT_COUNT), .TIME_WIDTH(TIME_WIDTH),
      .TICKS_PER_SECOND(TICKS)
   ) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   task automatic check(input string name, input logic [31:0] act, input int exp);
      n_cmp++;
      if (act !== 32'(exp)) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int entry_value();
      int v = 0;
      foreach (m_keys[k]) v = v * RADIX + m_keys[k];
      return v;
   endfunction

   function automatic snap_t model_snapshot();
      snap_t s;
      s.entered   = entry_value();
      s.digits    = m_keys.size();
      s.state     = m_mode;
      s.remaining = (m_mode == 1) ? m_secs - m_elapsed / TICKS : 0;
      s.valve     = (m_mode == 1) ? 1 : 0;
      s.done      = (m_mode == 2) ? 1 : 0;
      return s;
   endfunction

   function automatic int lowest_key(input logic [RADIX-1:0] sw);
      logic [RADIX-1:0] iso;
      int low = 0;
      iso = sw & (~sw + RADIX'(1));
      while (iso > RADIX'(1)) begin
         iso = iso >> 1;
         low++;
      end
      return low;
   endfunction

   initial begin
      forever begin
         @(posedge clock or posedge reset);
         if (reset) begin
            m_keys.delete();
            m_mode = 0;
            m_prev_add = 1'b1;
            m_prev_ok = 1'b1;
            m_prev_cancel = 1'b1;
            exp_q.delete();
         end else begin
            bit pa, po, pc;
            pc = bus.button_cancel && !m_prev_cancel;
            po = bus.button_ok && !m_prev_ok;
            pa = bus.button_add && !m_prev_add;
            m_prev_add    = bus.button_add;
            m_prev_ok     = bus.button_ok;
            m_prev_cancel = bus.button_cancel;
            case (m_mode)
               0: begin
                  if (pc) m_keys.delete();
                  else if (po) begin
                     if (entry_value() != 0) begin
                        m_secs    = entry_value();
                        m_elapsed = 0;
                        m_mode    = 1;
                     end
                  end else if (pa && bus.switches != '0 && m_keys.size() < DIGIT_COUNT)
                     m_keys.push_back(lowest_key(bus.switches));
               end
               1: begin
                  if (pc) begin
                     m_keys.delete();
                     m_mode = 0;
                  end else begin
                     m_elapsed++;
                     if (m_elapsed == m_secs * TICKS) m_mode = 2;
                  end
               end
               default: begin
                  m_keys.delete();
                  m_mode = 0;
               end
            endcase
         end
         exp_q.push_back(model_snapshot());
      end
   end

   initial begin
      snap_t e;
      forever begin
         @(negedge clock);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("entered_time",   32'(bus.entered_time),   e.entered);
            check("remaining_time", 32'(bus.remaining_time), e.remaining);
            check("digit_count",    32'(bus.digit_count),    e.digits);
            check("valve_open",     32'(bus.valve_open),     e.valve);
            check("done_pulse",     32'(bus.done_pulse),     e.done);
            check("state_code",     32'(bus.state_code),     e.state);
         end
      end
   end

   task automatic idle(input int n);
      repeat (n) @(negedge clock);
   endtask

   task automatic press(input bit a, input bit o, input bit c, input logic [RADIX-1:0] sw);
      @(negedge clock);
      bus.switches      = sw;
      bus.button_add    = a;
      bus.button_ok     = o;
      bus.button_cancel = c;
      @(negedge clock);
      bus.button_add    = 1'b0;
      bus.button_ok     = 1'b0;
      bus.button_cancel = 1'b0;
   endtask

   task automatic key(input int d);
      press(1'b1, 1'b0, 1'b0, RADIX'(1) << d);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1);
   end

   initial begin
      int open_cycles;
      bit seen;
      bus.switches      = RADIX'(1) << 3;
      bus.button_add    = 1'b1;
      bus.button_ok     = 1'b0;
      bus.button_cancel = 1'b0;
      #1 reset = 1'b1;
      idle(2);
      reset = 1'b0;

      // Add held through reset must not count; a fresh press must.
      idle(3);
      bus.button_add = 1'b0;
      idle(2);
      key(3);
      idle(2);

      press(1'b0, 1'b0, 1'b1, '0);
      press(1'b1, 1'b0, 1'b0, (RADIX'(1) << 2) | (RADIX'(1) << 7));
      key(5);
      idle(2);

      press(1'b0, 1'b0, 1'b1, '0);
      repeat (5) key(9);
      press(1'b1, 1'b0, 1'b0, '0);
      idle(2);

      press(1'b0, 1'b0, 1'b1, '0);
      key(3);
      press(1'b0, 1'b1, 1'b0, '0);
      open_cycles = 0;
      seen = 1'b0;
      for (int i = 0; i < 200; i++) begin
         if (bus.valve_open) begin
            open_cycles++;
            seen = 1'b1;
         end else if (seen) begin
            break;
         end
         @(negedge clock);
      end
      check("valve_open_cycles", 32'(open_cycles), 3 * TICKS);
      idle(3);

      key(5);
      press(1'b0, 1'b1, 1'b0, '0);
      idle(2 * TICKS + 1);
      press(1'b0, 1'b0, 1'b1, '0);
      idle(2);
      press(1'b0, 1'b1, 1'b0, '0);
      idle(3);

      key(7);
      press(1'b1, 1'b1, 1'b1, RADIX'(1) << 4);
      idle(3);

      key(2);
      press(1'b0, 1'b1, 1'b0, '0);
      idle(3);
      @(posedge clock);
      #2 reset = 1'b1;
      #1;
      check("async_valve_open", 32'(bus.valve_open), 0);
      check("async_state_code", 32'(bus.state_code), 0);
      check("async_remaining",  32'(bus.remaining_time), 0);
      @(negedge clock);
      reset = 1'b0;
      idle(2);

      for (int i = 0; i < 600; i++) begin
         @(negedge clock);
         case ($urandom_range(0, 3))
            0:       bus.switches = '0;
            1:       bus.switches = RADIX'(1) << $urandom_range(0, RADIX - 1);
            default: bus.switches = RADIX'($urandom);
         endcase
         bus.button_add    = ($urandom_range(0, 2) == 0);
         bus.button_ok     = ($urandom_range(0, 9) == 0);
         bus.button_cancel = ($urandom_range(0, 24) == 0);
      end
      @(negedge clock);
      bus.button_add    = 1'b0;
      bus.button_ok     = 1'b0;
      bus.button_cancel = 1'b0;
      idle(5);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

`default_nettype wire
